// File: rtl/div_step_sequencer.sv
// Radix-4 restoring divider: two quotient bits per cycle, WIDTH/2 iteration cycles.
// Optional DIV_ZERO_DETECT_EN: a zero divisor short-circuits straight to DONE and flags div_by_zero.
module div_step_sequencer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [IDX_W-1:0] idx_reg;

  logic [IDX_W-1:0] idx_lo;
  logic [WIDTH:0]   shift_hi;
  logic [WIDTH:0]   rem_mid;
  logic [WIDTH:0]   shift_lo;
  logic [WIDTH:0]   rem_next;
  logic             bit_hi;
  logic             bit_lo;
  logic [WIDTH-1:0] quo_next;
  logic             last_step;

  // Two chained shift / trial-subtract / restore steps on bits idx and idx-1.
  // The extra remainder bit keeps the shifted value from overflowing before the compare.
  always_comb begin
    idx_lo    = idx_reg - IDX_W'(1);
    shift_hi  = {rem_reg[WIDTH-1:0], n_reg[idx_reg]};
    bit_hi    = (shift_hi >= {1'b0, d_reg});
    rem_mid   = bit_hi ? (shift_hi - {1'b0, d_reg}) : shift_hi;
    shift_lo  = {rem_mid[WIDTH-1:0], n_reg[idx_lo]};
    bit_lo    = (shift_lo >= {1'b0, d_reg});
    rem_next  = bit_lo ? (shift_lo - {1'b0, d_reg}) : shift_lo;
    quo_next  = {quo_reg[WIDTH-3:0], bit_hi, bit_lo};
    last_step = (idx_reg == IDX_W'(1));
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_reg;
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      d_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            n_reg   <= dividend;
            d_reg   <= divisor;
            quo_reg <= '0;
            rem_reg <= '0;
            idx_reg <= IDX_W'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == '0) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              dbz_reg   <= 1'b1;
            end else begin
              state_reg <= ITER;
              busy      <= 1'b1;
              dbz_reg   <= 1'b0;
            end
`else
            state_reg <= ITER;
            busy      <= 1'b1;
`endif
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        ITER: begin
          if (abort) begin
            // Results stay at their previous values; the partial work is simply dropped.
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (last_step) begin
              idx_reg   <= '0;
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= quo_next;
              remainder <= rem_next[WIDTH-1:0];
            end else begin
              idx_reg <= idx_reg - IDX_W'(2);
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_step_sequencer.sv
// Directed bench for div_step_sequencer (WIDTH=10); honours DIV_ZERO_DETECT_EN when defined.
module tb_div_step_sequencer;

  localparam int W   = 10;
  localparam int LAT = W / 2;
`ifdef DIV_ZERO_DETECT_EN
  localparam int ZLAT = 0;
  localparam int EDBZ = 1;
`else
  localparam int ZLAT = LAT;
  localparam int EDBZ = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  div_step_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a division and checks busy/done over the whole latency; leaves the DUT in DONE.
  task automatic do_div(input string tag, input int n, input int d, input int lat,
                        input int eq, input int er, input int edbz);
    dividend = W'(n);
    divisor  = W'(d);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < lat; c++) begin
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_nodone"}, 32'(done), 0);
      tick();
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_q"}, 32'(quotient), eq);
    check({tag, "_r"}, 32'(remainder), er);
    check({tag, "_dbz"}, 32'(div_by_zero), edbz);
    $display("div %s N=%0d D=%0d -> Q=%0d R=%0d dbz=%0d", tag, n, d, quotient, remainder, div_by_zero);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_q"}, 32'(quotient), 0);
    check({tag, "_r"}, 32'(remainder), 0);
    check({tag, "_dbz"}, 32'(div_by_zero), 0);
  endtask

  initial begin
    // Reset state
    #1;
    check_zero_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    check_zero_outputs("rst_rel");
    $display("reset released");

    // Basic division
    do_div("t1", 10, 5, LAT, 2, 0, 0);
    tick();
    check("t1_done_pulse", 32'(done), 0);

    // Back-to-back start accepted in the DONE cycle
    do_div("t2", 86, 14, LAT, 6, 2, 0);
    do_div("t2b", 1023, 1, LAT, 1023, 0, 0);
    tick();
    check("t2b_done_pulse", 32'(done), 0);

    // Abort on the 3rd ITER cycle: results from t2b must be held
    dividend = W'(86);
    divisor  = W'(14);
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t3_busy", 32'(busy), 1);
    check("t3_q_hold_iter", 32'(quotient), 1023);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_idle_busy", 32'(busy), 0);
    check("t3_q_held", 32'(quotient), 1023);
    check("t3_r_held", 32'(remainder), 0);
    for (int c = 0; c < 6; c++) begin
      check("t3_no_done", 32'(done), 0);
      tick();
    end
    $display("abort N=86 D=14 -> Q=%0d R=%0d held", quotient, remainder);

    // start during ITER with new operands is ignored
    dividend = W'(86);
    divisor  = W'(14);
    start    = 1'b1;
    tick();
    dividend = W'(5);
    divisor  = W'(5);
    for (int c = 0; c < LAT; c++) begin
      check("t4_busy", 32'(busy), 1);
      if (c == 2) start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("t4_done", 32'(done), 1);
    check("t4_q", 32'(quotient), 6);
    check("t4_r", 32'(remainder), 2);
    $display("div t4 N=86 D=14 (restart ignored) -> Q=%0d R=%0d", quotient, remainder);
    tick();

    // Divide by zero
    do_div("t5", 86, 0, ZLAT, 1023, 86, EDBZ);
    tick();
    check("t5_done_pulse", 32'(done), 0);
    check("t5_dbz_hold", 32'(div_by_zero), EDBZ);

    // Reset mid-ITER clears everything immediately, no done afterwards
    dividend = W'(86);
    divisor  = W'(14);
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("t6_dbz_clear", 32'(div_by_zero), 0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_async");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t6_no_done", 32'(done), 0);
      check("t6_idle", 32'(busy), 0);
    end
    $display("reset mid-iteration discarded operation");
    do_div("t6b", 10, 5, LAT, 2, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_step_sequencer.md
DIV_STEP_SEQUENCER -- requirements
Module: div_step_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, operand/result width in bits; WIDTH SHALL be even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new division; sampled on the rising clk edge.
REQ-005 SHALL have port abort  input  1  cancel an in-flight division.
REQ-006 SHALL have port dividend  input  WIDTH  unsigned numerator N; latched when start is accepted.
REQ-007 SHALL have port divisor  input  WIDTH  unsigned denominator D; latched when start is accepted.
REQ-008 SHALL have port busy  output  1  high while iterating.
REQ-009 SHALL have port done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 SHALL have port quotient  output  WIDTH  Q = N / D.
REQ-011 SHALL have port remainder  output  WIDTH  R = N mod D.
REQ-012 SHALL have port div_by_zero  output  1  D was zero for the current result.

Function
REQ-013 SHALL implement states IDLE, ITER, DONE.
REQ-014 IDLE or DONE, start=1: SHALL latch N and D, clear partial remainder and quotient, load the bit index to WIDTH-1, and enter ITER.
REQ-015 start in ITER SHALL be ignored; latched operands SHALL NOT change.
REQ-016 ITER: each cycle SHALL retire 2 quotient bits by radix-4 restoring steps, MSB first (two shift/trial-subtract/restore steps on bits index and index-1); index decrements by 2.
REQ-017 Partial remainder SHALL be WIDTH+1 bits internally, so trial subtraction cannot overflow.
REQ-018 ITER SHALL last exactly WIDTH/2 cycles; the next state SHALL be DONE.
REQ-019 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE unless start=1 (REQ-014).
REQ-020 Latency: done SHALL be high WIDTH/2+1 cycles after the start-accept edge (6 for WIDTH=10).
REQ-021 busy SHALL be 1 exactly in ITER.
REQ-022 quotient/remainder SHALL update only when entering DONE and hold until the next DONE, including across aborts.
REQ-023 abort=1 in ITER SHALL go to IDLE on the next edge with no done pulse and outputs unchanged.
REQ-024 If abort and start are both 1, abort SHALL win in ITER; start SHALL win in IDLE/DONE, where abort has no effect.
REQ-025 D=0 without the detector SHALL run the full latency and give quotient all ones and remainder = N; div_by_zero SHALL be 0.

Reset
REQ-026 rst=1 SHALL force, asynchronously, state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and index and internal registers to 0.
REQ-027 Reset during ITER SHALL discard the operation; no done SHALL follow the release of reset.

Configuration
REQ-028 Macro DIV_ZERO_DETECT_EN defined: a start accepted with D=0 SHALL go directly to DONE in one cycle (done 1 cycle after accept), with quotient all ones, remainder = N, and div_by_zero=1. div_by_zero SHALL clear on the next accepted start with D!=0.
REQ-029 Macro DIV_ZERO_DETECT_EN undefined: no detection logic; div_by_zero SHALL be tied to 0; behaviour per REQ-025.

Verification
REQ-030 N=10, D=5, start 1 cycle -> busy 5 cycles, done at accept+6, quotient=2, remainder=0.
REQ-031 N=86, D=14 -> quotient=6, remainder=2; with back-to-back start in the DONE cycle using N=1023, D=1 -> quotient=1023, remainder=0 after 6 further cycles.
REQ-032 N=86, D=14, start re-asserted with N=5, D=5 during ITER -> ignored; result quotient=6, remainder=2.
REQ-033 N=86, D=14, abort at 3rd ITER cycle -> IDLE next edge, no done, prior quotient/remainder held.
REQ-034 N=86, D=0 -> with DIV_ZERO_DETECT_EN: done at accept+1, quotient=1023, remainder=86, div_by_zero=1; without: done at accept+6, same quotient/remainder, div_by_zero=0.
REQ-035 rst pulsed mid-ITER -> all outputs 0 immediately, no done afterwards; a new start with N=10, D=5 then completes normally.
